cattrap_move_capture: RTL and testbench
=======================================

// Module: cattrap_move_capture
// PURPOSE
//  Upstream input stage for the CatTrap game core. Synchronises and debounces BtnU.
//  On each debounced press it samples the one-hot Row/Col switch banks and validates them.
//  It encodes a legal selection to 3-bit indices and offers it to the core via valid/ready.
//  Illegal selections (not exactly one bit set per bank) raise a 1-cycle error pulse.
// PARAMETERS
//  DEBOUNCE_CYCLES  1000000  consecutive stable cycles before debounced button changes (10 ms @100 MHz)
//  CNT_W            20       debounce counter width; must hold DEBOUNCE_CYCLES-1
// PORTS
//  clk         in   1  system clock, 100 MHz
//  Reset       in   1  asynchronous, active-high reset
//  BtnU        in   1  raw "place move" button, asynchronous
//  Row         in   8  raw row switches, one-hot, asynchronous
//  Col         in   8  raw column switches, one-hot, asynchronous
//  move_ready  in   1  game core accepts the offered move
//  move_valid  out  1  move offered; held until accepted
//  move_row    out  3  encoded row index (bit position of the set Row bit)
//  move_col    out  3  encoded column index
//  err_pulse   out  1  1-cycle pulse: selection rejected
//  move_count  out  8  accepted-move counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all sync flops 0, debounced button 0, counter 0, state IDLE.
//  Reset values: move_valid=0, move_row=0, move_col=0, err_pulse=0, move_count=0.
//  Sync: BtnU, Row and Col each pass through 2 flops (s1, s2). Only s2 values are used.
//  Debounce: when btn_s2 != btn_db, the counter increments; otherwise the counter clears to 0.
//   btn_db toggles on the DEBOUNCE_CYCLES-th consecutive mismatch edge; the counter then clears.
//  FSM states:
//   IDLE:   on btn_db rising edge (btn_db=1, btn_db_q=0), register Row_s2/Col_s2 -> CHECK.
//   CHECK:  both banks exactly one-hot -> encode, OFFER.
//           Otherwise -> err_pulse=1 for this cycle only, then RELEASE.
//   OFFER:  move_valid=1. move_row/move_col are stable while valid is high.
//           On move_valid & move_ready at an edge: transfer occurs -> RELEASE, valid drops next cycle.
//   RELEASE: wait for btn_db=0 -> IDLE. This stops one press from producing two moves.
//  Latency: BtnU held high from edge 1 -> move_valid high after edge DEBOUNCE_CYCLES+4.
//   move_ready already high at that point -> transfer on edge DEBOUNCE_CYCLES+5.
//  Switch changes after the CHECK sample do not alter the offered move.
//  Presses during CHECK, OFFER or RELEASE are ignored and never queued.
//  Bounce shorter than DEBOUNCE_CYCLES produces no press.
//  move_ready while not OFFER has no effect.
//  Reset mid-OFFER drops move_valid immediately (async) and discards the move.
//  All-zero or multi-bit bank -> error. A single error pulse per press.
// CONFIGURATION
//  CATTRAP_MOVE_COUNT_EN defined:
//   move_count increments by 1 on every accepted transfer.
//   8-bit wrap: 255 -> 0. Cleared only by Reset.
//  Not defined: move_count is tied to 8'd0 and no counter flops are built.
// TESTING (bench uses DEBOUNCE_CYCLES=4)
//  1. Row=8'h04, Col=8'h80, BtnU high, move_ready=1:
//     -> move_valid high after edge 8, row=2, col=7, accepted at edge 9, err_pulse never.
//  2. Row=8'h00 or 8'h18, Col=8'h01, press:
//     -> err_pulse high exactly 1 cycle, move_valid stays 0, FSM returns IDLE after release.
//  3. BtnU toggling every 2 cycles for 40 cycles:
//     -> no move_valid, no err_pulse. Then held 10 cycles -> exactly one move.
//  4. move_ready=0 for 20 cycles during OFFER while Row changes to 8'h01:
//     -> valid stays high, row unchanged. ready=1 -> one transfer, valid low next cycle.
//  5. Hold BtnU 50 cycles after transfer:
//     -> no second move. Release, press again -> second move.
//  6. Reset asserted mid-OFFER:
//     -> move_valid=0 immediately. With CATTRAP_MOVE_COUNT_EN: 256 moves -> move_count=0.

Source files
------------

// File: rtl/cattrap_move_capture_if.sv
// Move handshake between the CatTrap input stage and the game core.
//   move_valid  producer -> consumer  move offered, held until accepted
//   move_ready  consumer -> producer  consumer accepts the offered move
//   move_row    producer -> consumer  3-bit row index of the offered move
//   move_col    producer -> consumer  3-bit column index of the offered move
// Modports: master (input stage), slave (game core).
interface cattrap_move_capture_if;
  logic       move_valid;
  logic       move_ready;
  logic [2:0] move_row;
  logic [2:0] move_col;

  modport master (output move_valid, output move_row, output move_col, input move_ready);
  modport slave  (input move_valid, input move_row, input move_col, output move_ready);
endinterface

// File: rtl/cattrap_move_capture.sv
// cattrap_move_capture: upstream input stage for the CatTrap game core.
// Synchronises and debounces BtnU. Each debounced press samples the one-hot
// Row/Col switch banks; a legal selection is encoded to 3-bit indices and
// offered on the move handshake, an illegal one raises a 1-cycle err_pulse.
// Ports:
//   clk         system clock
//   Reset       asynchronous, active-high reset
//   BtnU        raw "place move" button (asynchronous)
//   Row, Col    raw one-hot switch banks (asynchronous)
//   mv          move handshake (master): move_valid/move_ready/move_row/move_col
//   err_pulse   1-cycle pulse: selection rejected
//   move_count  accepted-move counter
// Optional feature macro: CATTRAP_MOVE_COUNT_EN
//   defined     -> move_count counts accepted transfers, 8-bit wrap, Reset-only clear
//   not defined -> move_count is tied to zero and no counter flops exist
module cattrap_move_capture #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic                         clk,
  input  logic                         Reset,
  input  logic                         BtnU,
  input  logic [7:0]                   Row,
  input  logic [7:0]                   Col,
  cattrap_move_capture_if.master       mv,
  output logic                         err_pulse,
  output logic [7:0]                   move_count
);

  typedef enum logic [1:0] {IDLE, CHECK, OFFER, RELEASE} state_t;

  state_t state, state_n;

  logic             btn_s1, btn_s2;
  logic [7:0]       row_s1, row_s2, col_s1, col_s2;
  logic [CNT_W-1:0] db_cnt;
  logic             btn_db, btn_db_q;
  logic [7:0]       row_cap, col_cap;
  logic [2:0]       row_q, col_q;
  logic             legal;
  logic             press;

  function automatic logic is_onehot(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

  function automatic logic [2:0] enc(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Two-flop synchronisers; only the s2 stage is consumed downstream.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      row_s1 <= '0;
      row_s2 <= '0;
      col_s1 <= '0;
      col_s2 <= '0;
    end else begin
      btn_s1 <= BtnU;
      btn_s2 <= btn_s1;
      row_s1 <= Row;
      row_s2 <= row_s1;
      col_s1 <= Col;
      col_s2 <= col_s1;
    end
  end

  // Debounce: count consecutive mismatch cycles; the DEBOUNCE_CYCLES-th one
  // flips btn_db. Any agreement restarts the count.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      db_cnt   <= '0;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
    end else begin
      btn_db_q <= btn_db;
      if (btn_s2 != btn_db) begin
        if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          btn_db <= btn_s2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + CNT_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign press = btn_db && !btn_db_q;
  assign legal = is_onehot(row_cap) && is_onehot(col_cap);

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n       = state;
    err_pulse     = 1'b0;
    mv.move_valid = 1'b0;
    case (state)
      IDLE:    if (press) state_n = CHECK;
      CHECK: begin
        if (legal) begin
          state_n = OFFER;
        end else begin
          err_pulse = 1'b1;
          state_n   = RELEASE;
        end
      end
      OFFER: begin
        mv.move_valid = 1'b1;
        if (mv.move_ready) state_n = RELEASE;
      end
      RELEASE: if (!btn_db) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Selection is frozen at the press and the encoded indices at CHECK, so
  // later switch movement cannot disturb an outstanding offer.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      row_cap <= '0;
      col_cap <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      if (state == IDLE && press) begin
        row_cap <= row_s2;
        col_cap <= col_s2;
      end
      if (state == CHECK && legal) begin
        row_q <= enc(row_cap);
        col_q <= enc(col_cap);
      end
    end
  end

  assign mv.move_row = row_q;
  assign mv.move_col = col_q;

`ifdef CATTRAP_MOVE_COUNT_EN
  logic [7:0] cnt_q;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset)                                cnt_q <= '0;
    else if (state == OFFER && mv.move_ready) cnt_q <= cnt_q + 8'd1;
  end

  assign move_count = cnt_q;
`else
  assign move_count = '0;
`endif

endmodule

// File: tb/tb_cattrap_move_capture.sv
module tb_cattrap_move_capture;

  typedef struct packed {
    logic       err;
    logic [2:0] row;
    logic [2:0] col;
  } exp_t;

  logic       clk = 1'b0;
  logic       Reset;
  logic       BtnU;
  logic [7:0] Row, Col;
  logic       err_pulse;
  logic [7:0] move_count;

  cattrap_move_capture_if mv_if ();

  cattrap_move_capture #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .Reset(Reset),
    .BtnU(BtnU),
    .Row(Row),
    .Col(Col),
    .mv(mv_if.master),
    .err_pulse(err_pulse),
    .move_count(move_count)
  );

  always #5 clk = ~clk;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         err_seen = 0;
  int         xfer_seen = 0;
  logic       err_prev = 1'b0;
  logic [7:0] exp_count = 8'd0;

  function automatic exp_t model(input logic [7:0] r, input logic [7:0] c);
    exp_t e;
    if ($countones(r) == 1 && $countones(c) == 1) begin
      e.err = 1'b0;
      e.row = 3'($clog2(r));
      e.col = 3'($clog2(c));
    end else begin
      e.err = 1'b1;
      e.row = 3'd0;
      e.col = 3'd0;
    end
    return e;
  endfunction

  // Scoreboard monitor: samples on the falling edge, ahead of the next
  // rising edge at which a valid&ready transfer takes place.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!Reset) begin
      if (err_pulse) begin
        err_seen++;
        checks++;
        if (err_prev) begin
          errors++;
          $display("FAIL err_width: err_pulse high 2 cycles, required 1");
        end else if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_err: err_pulse=1 with no press pending, required 0");
        end else begin
          e = sb.pop_front();
          if (e.err !== 1'b1) begin
            errors++;
            $display("FAIL err_kind: got error, required move row=%0d col=%0d", e.row, e.col);
          end
        end
      end
      if (mv_if.move_valid && mv_if.move_ready) begin
        xfer_seen++;
`ifdef CATTRAP_MOVE_COUNT_EN
        exp_count = exp_count + 8'd1;
`endif
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_move: row=%0d col=%0d, required no transfer",
                   mv_if.move_row, mv_if.move_col);
        end else begin
          e = sb.pop_front();
          if (e.err !== 1'b0 || mv_if.move_row !== e.row || mv_if.move_col !== e.col) begin
            errors++;
            $display("FAIL move_data: got err=0 row=%0d col=%0d, required err=%0d row=%0d col=%0d",
                     mv_if.move_row, mv_if.move_col, e.err, e.row, e.col);
          end
        end
      end
    end
    err_prev = err_pulse && !Reset;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [7:0] r, input logic [7:0] c, input int hold);
    Row  = r;
    Col  = c;
    sb.push_back(model(r, c));
    BtnU = 1'b1;
    tick(hold);
    BtnU = 1'b0;
    tick(12);
  endtask

  task automatic wait_valid(input string name);
    int t;
    t = 0;
    while (mv_if.move_valid !== 1'b1 && t < 40) begin
      tick(1);
      t++;
    end
    checks++;
    if (mv_if.move_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: move_valid=%b after 40 cycles, required 1", name, mv_if.move_valid);
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    BtnU  = 1'b0;
    Row   = 8'h00;
    Col   = 8'h00;
    mv_if.move_ready = 1'b1;
    tick(2);
    checks += 5;
    if (mv_if.move_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", mv_if.move_valid); end
    if (mv_if.move_row !== 3'd0)   begin errors++; $display("FAIL rst_row: got %0d required 0", mv_if.move_row); end
    if (mv_if.move_col !== 3'd0)   begin errors++; $display("FAIL rst_col: got %0d required 0", mv_if.move_col); end
    if (err_pulse !== 1'b0)        begin errors++; $display("FAIL rst_err: got %b required 0", err_pulse); end
    if (move_count !== 8'd0)       begin errors++; $display("FAIL rst_count: got %0d required 0", move_count); end
    Reset = 1'b0;
    tick(3);
    checks++;
    if (mv_if.move_valid !== 1'b0) begin errors++; $display("FAIL post_rst_valid: got %b required 0", mv_if.move_valid); end
  endtask

  task automatic test_latency;
    Row = 8'h04;
    Col = 8'h80;
    mv_if.move_ready = 1'b1;
    sb.push_back(model(Row, Col));
    BtnU = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick(1);
      if (k == 7) begin
        checks++;
        if (mv_if.move_valid !== 1'b0) begin errors++; $display("FAIL lat_early: valid=%b after edge 7, required 0", mv_if.move_valid); end
      end
      if (k == 8) begin
        checks++;
        if (mv_if.move_valid !== 1'b1 || mv_if.move_row !== 3'd2 || mv_if.move_col !== 3'd7) begin
          errors++;
          $display("FAIL lat_offer: valid=%b row=%0d col=%0d after edge 8, required 1 2 7",
                   mv_if.move_valid, mv_if.move_row, mv_if.move_col);
        end
      end
      if (k == 9) begin
        checks++;
        if (mv_if.move_valid !== 1'b0) begin errors++; $display("FAIL lat_drop: valid=%b after edge 9, required 0", mv_if.move_valid); end
      end
    end
    BtnU = 1'b0;
    tick(12);
  endtask

  task automatic test_error;
    logic [7:0] pats [2];
    int e0, x0;
    pats[0] = 8'h00;
    pats[1] = 8'h18;
    for (int i = 0; i < 2; i++) begin
      e0 = err_seen;
      x0 = xfer_seen;
      press(pats[i], 8'h01, 10);
      checks++;
      if (err_seen - e0 != 1 || xfer_seen != x0) begin
        errors++;
        $display("FAIL err_count row=%h: err=%0d xfer=%0d, required err=1 xfer=0",
                 pats[i], err_seen - e0, xfer_seen - x0);
      end
    end
    x0 = xfer_seen;
    press(8'h02, 8'h08, 10);
    checks++;
    if (xfer_seen != x0 + 1) begin errors++; $display("FAIL err_recover: xfer=%0d required 1", xfer_seen - x0); end
  endtask

  task automatic test_bounce;
    int e0, x0;
    e0 = err_seen;
    x0 = xfer_seen;
    Row = 8'h10;
    Col = 8'h02;
    for (int i = 0; i < 20; i++) begin
      BtnU = ~BtnU;
      tick(2);
    end
    checks++;
    if (xfer_seen != x0 || err_seen != e0) begin
      errors++;
      $display("FAIL bounce: xfer=%0d err=%0d, required 0 0", xfer_seen - x0, err_seen - e0);
    end
    press(8'h10, 8'h02, 10);
    checks++;
    if (xfer_seen != x0 + 1) begin errors++; $display("FAIL bounce_hold: xfer=%0d required 1", xfer_seen - x0); end
  endtask

  task automatic test_stall;
    int bad;
    mv_if.move_ready = 1'b0;
    Row = 8'h08;
    Col = 8'h04;
    sb.push_back(model(Row, Col));
    BtnU = 1'b1;
    wait_valid("stall");
    Row = 8'h01;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (mv_if.move_valid !== 1'b1 || mv_if.move_row !== 3'd3 || mv_if.move_col !== 3'd2) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL stall_hold: %0d bad cycles, required 0 (valid=1 row=3 col=2)", bad); end
    mv_if.move_ready = 1'b1;
    tick(1);
    checks++;
    if (mv_if.move_valid !== 1'b0) begin errors++; $display("FAIL stall_drop: valid=%b required 0", mv_if.move_valid); end
    BtnU = 1'b0;
    tick(12);
  endtask

  task automatic test_hold;
    int x0;
    x0 = xfer_seen;
    Row = 8'h20;
    Col = 8'h02;
    sb.push_back(model(Row, Col));
    BtnU = 1'b1;
    tick(60);
    checks++;
    if (xfer_seen != x0 + 1) begin errors++; $display("FAIL hold_single: xfer=%0d required 1", xfer_seen - x0); end
    BtnU = 1'b0;
    tick(12);
    press(8'h40, 8'h40, 10);
    checks++;
    if (xfer_seen != x0 + 2) begin errors++; $display("FAIL hold_second: xfer=%0d required 2", xfer_seen - x0); end
  endtask

  task automatic test_reset_offer;
    exp_t dropped;
    mv_if.move_ready = 1'b0;
    Row = 8'h01;
    Col = 8'h01;
    sb.push_back(model(Row, Col));
    BtnU = 1'b1;
    wait_valid("rstoffer");
    #3;
    Reset = 1'b1;
    #1;
    checks++;
    if (mv_if.move_valid !== 1'b0) begin errors++; $display("FAIL rst_offer: valid=%b required 0", mv_if.move_valid); end
    if (sb.size() > 0) dropped = sb.pop_back();
    exp_count = 8'd0;
    BtnU = 1'b0;
    mv_if.move_ready = 1'b1;
    tick(3);
    Reset = 1'b0;
    tick(12);
    checks++;
    if (mv_if.move_valid !== 1'b0 || move_count !== 8'd0) begin
      errors++;
      $display("FAIL rst_offer_after: valid=%b count=%0d required 0 0", mv_if.move_valid, move_count);
    end
  endtask

  task automatic test_count;
    int n;
`ifdef CATTRAP_MOVE_COUNT_EN
    n = 256;
`else
    n = 3;
`endif
    for (int i = 0; i < n; i++) begin
      press(8'h80, 8'h01, 10);
      if (i == n - 2) begin
        checks++;
        if (move_count !== exp_count) begin errors++; $display("FAIL count_mid: got %0d required %0d", move_count, exp_count); end
      end
    end
    checks++;
    if (move_count !== exp_count) begin errors++; $display("FAIL count_end: got %0d required %0d", move_count, exp_count); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_error();
    test_bounce();
    test_stall();
    test_hold();
    test_reset_offer();
    test_count();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: %0d pending, required 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
